// File: rtl/hit_judge.sv
// hit_judge: debounces player switches into strikes and judges them against the
// current mole wave, producing hit/miss pulses and saturating score/combo/miss counters.
module hit_judge #(
    parameter int NUM_HOLES       = 18,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCORE_WIDTH     = 16,
    parameter int COMBO_WIDTH     = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_HOLES-1:0]   mole_positions,
    input  logic [NUM_HOLES-1:0]   switches,
    input  logic                   game_in_progress,
    output logic [NUM_HOLES-1:0]   LEDs,
    output logic                   miss,
    output logic                   non_full_clear_hit,
    output logic                   full_clear_hit,
    output logic [SCORE_WIDTH-1:0] score,
    output logic [COMBO_WIDTH-1:0] combo,
    output logic [COMBO_WIDTH-1:0] miss_count
);
    localparam logic [7:0] LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam int         SUM_W = SCORE_WIDTH + 6;

    logic [NUM_HOLES-1:0]   sync1_q, sync2_q, acc_q, acc_d, fire, strike_q;
    logic [7:0]             cnt_q [NUM_HOLES];
    logic [7:0]             cnt_d [NUM_HOLES];
    logic [NUM_HOLES-1:0]   mole_q, live_q, live_d, hits, misses;
    logic                   game_q, start, wave, active, hit_any, miss_any;
    logic                   miss_q, miss_d, nfc_q, nfc_d, fc_q, fc_d;
    logic [5:0]             hit_cnt;
    logic [SUM_W-1:0]       sum;
    logic [SCORE_WIDTH-1:0] score_q, score_d;
    logic [COMBO_WIDTH-1:0] combo_q, combo_d, mcnt_q, mcnt_d;

    // Counter holds the number of consecutive cycles the synchronised level has disagreed.
    always_comb begin
        fire = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            fire[i]  = (sync2_q[i] != acc_q[i]) && (cnt_q[i] == LAST);
            cnt_d[i] = (sync2_q[i] != acc_q[i] && !fire[i]) ? cnt_q[i] + 8'd1 : 8'd0;
        end
        acc_d = acc_q ^ fire;
    end

    always_comb begin
        start    = game_in_progress && !game_q;
        wave     = start || (mole_positions != mole_q);
        active   = game_in_progress && !wave;
        hits     = strike_q & live_q;
        misses   = strike_q & ~live_q;
        hit_any  = active && (hits != '0);
        miss_any = active && (misses != '0);
        hit_cnt  = '0;
        for (int i = 0; i < NUM_HOLES; i++)
            hit_cnt = hit_cnt + 6'(hits[i]);
        sum      = SUM_W'(score_q) + SUM_W'(hit_cnt);
        live_d   = !game_in_progress ? '0 : wave ? mole_positions : live_q & ~hits;
        miss_d   = miss_any;
        fc_d     = hit_any && (live_d == '0);
        nfc_d    = hit_any && (live_d != '0);
        score_d  = start ? '0 : !hit_any ? score_q :
                   (sum > SUM_W'({SCORE_WIDTH{1'b1}})) ? '1 : sum[SCORE_WIDTH-1:0];
        combo_d  = (start || miss_any) ? '0 :
                   (!hit_any || combo_q == '1) ? combo_q : combo_q + COMBO_WIDTH'(1);
        mcnt_d   = start ? '0 : (!miss_any || mcnt_q == '1) ? mcnt_q : mcnt_q + COMBO_WIDTH'(1);
    end

    // Reset seeds the synchronisers from the live switch levels so held switches never strike.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q  <= switches;
            sync2_q  <= switches;
            acc_q    <= switches;
            strike_q <= '0;
            for (int i = 0; i < NUM_HOLES; i++)
                cnt_q[i] <= '0;
            mole_q   <= mole_positions;
            game_q   <= 1'b0;
            live_q   <= '0;
            miss_q   <= 1'b0;
            nfc_q    <= 1'b0;
            fc_q     <= 1'b0;
            score_q  <= '0;
            combo_q  <= '0;
            mcnt_q   <= '0;
        end else begin
            sync1_q  <= switches;
            sync2_q  <= sync1_q;
            acc_q    <= acc_d;
            strike_q <= fire;
            for (int i = 0; i < NUM_HOLES; i++)
                cnt_q[i] <= cnt_d[i];
            mole_q   <= mole_positions;
            game_q   <= game_in_progress;
            live_q   <= live_d;
            miss_q   <= miss_d;
            nfc_q    <= nfc_d;
            fc_q     <= fc_d;
            score_q  <= score_d;
            combo_q  <= combo_d;
            mcnt_q   <= mcnt_d;
        end
    end

    assign LEDs               = live_q;
    assign miss               = miss_q;
    assign non_full_clear_hit = nfc_q;
    assign full_clear_hit     = fc_q;
    assign score              = score_q;
    assign combo              = combo_q;
    assign miss_count         = mcnt_q;
endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge: randomized and directed checks of hit_judge against a window-based reference model.
module tb_hit_judge;
    localparam int N = 18, D = 4, SW = 16, CW = 8, HL = D + 3, OW = N + 3 + SW + 2 * CW;
    localparam int MAXS = (1 << SW) - 1, MAXC = (1 << CW) - 1;

    logic          clk = 1'b0, reset_n = 1'b0, game_in_progress = 1'b0;
    logic [N-1:0]  mole_positions = '0, switches = '0;
    logic [N-1:0]  LEDs;
    logic          miss, non_full_clear_hit, full_clear_hit;
    logic [SW-1:0] score;
    logic [CW-1:0] combo, miss_count;
    int            tests = 0, fails = 0;

    hit_judge #(.NUM_HOLES(N), .DEBOUNCE_CYCLES(D), .SCORE_WIDTH(SW), .COMBO_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .mole_positions(mole_positions), .switches(switches),
        .game_in_progress(game_in_progress), .LEDs(LEDs), .miss(miss),
        .non_full_clear_hit(non_full_clear_hit), .full_clear_hit(full_clear_hit),
        .score(score), .combo(combo), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Reference: a hole strikes when the D samples taken 3..D+2 edges ago all disagree with its accepted level.
    logic [N-1:0] hist [HL];
    logic [N-1:0] m_acc, m_live, m_mole, m_strike, m_hits, m_misses;
    logic         m_game, m_miss, m_nf, m_fc;
    int           m_score, m_combo, m_mc, m_nd;

    wire [OW-1:0] obs   = {LEDs, miss, non_full_clear_hit, full_clear_hit, score, combo, miss_count};
    wire [OW-1:0] exp_v = {m_live, m_miss, m_nf, m_fc, SW'(m_score), CW'(m_combo), CW'(m_mc)};

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < HL; k++) hist[k] = switches;
            m_acc = switches; m_live = '0; m_mole = mole_positions; m_game = 1'b0;
            m_score = 0; m_combo = 0; m_mc = 0; {m_miss, m_nf, m_fc} = 3'b000;
        end else begin
            for (int k = HL - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = switches;
            m_strike = '0;
            for (int h = 0; h < N; h++) begin
                m_nd = 0;
                for (int k = 3; k < D + 3; k++) if (hist[k][h] != m_acc[h]) m_nd++;
                if (m_nd == D) begin m_strike[h] = 1'b1; m_acc[h] = ~m_acc[h]; end
            end
            {m_miss, m_nf, m_fc} = 3'b000;
            if (!game_in_progress) m_live = '0;
            else if (!m_game || mole_positions != m_mole) begin
                m_live = mole_positions;
                if (!m_game) begin m_score = 0; m_combo = 0; m_mc = 0; end
            end else begin
                m_hits = m_strike & m_live;
                m_misses = m_strike & ~m_live;
                m_live = m_live & ~m_hits;
                if (m_hits != '0) begin
                    m_score = (m_score + $countones(m_hits) > MAXS) ? MAXS : m_score + $countones(m_hits);
                    if (m_misses == '0) m_combo = (m_combo == MAXC) ? MAXC : m_combo + 1;
                    m_fc = (m_live == '0);
                    m_nf = !m_fc;
                end
                if (m_misses != '0) begin
                    m_miss = 1'b1; m_combo = 0; m_mc = (m_mc == MAXC) ? MAXC : m_mc + 1;
                end
            end
            m_mole = mole_positions; m_game = game_in_progress;
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        switches = N'($urandom); reset_n = 1'b0;
        repeat (3) begin
            cyc(); tests++;
            if (obs !== '0) begin fails++; $display("FAIL reset_zero: got %h expected 0", obs); end
        end
        reset_n = 1'b1;
        repeat (4) begin
            cyc(); tests++;
            if (obs !== exp_v) begin fails++; $display("FAIL reset_release: got %h expected %h", obs, exp_v); end
        end
    endtask

    task automatic test_full_clear();
        int bits[3] = '{17, 15, 13};
        int nf = 0, fc = 0, first;
        mole_positions = 18'h2A000; game_in_progress = 1'b1;
        repeat (3) begin
            cyc(); tests++;
            if (obs !== exp_v) begin fails++; $display("FAIL clear_setup: got %h expected %h", obs, exp_v); end
        end
        foreach (bits[j]) begin
            switches[bits[j]] = ~switches[bits[j]];
            first = -1;
            for (int k = 1; k <= 9; k++) begin
                cyc(); tests++;
                if (obs !== exp_v) begin fails++; $display("FAIL clear_model: got %h expected %h", obs, exp_v); end
                if ((non_full_clear_hit || full_clear_hit) && first < 0) first = k;
                nf += int'(non_full_clear_hit); fc += int'(full_clear_hit);
            end
            tests++;
            if (first != 7) begin fails++; $display("FAIL clear_latency: got %0d expected 7", first); end
        end
        tests++;
        if (nf != 2 || fc != 1) begin fails++; $display("FAIL clear_pulses: got nf=%0d fc=%0d expected 2 1", nf, fc); end
        tests++;
        if (LEDs !== '0 || score !== 16'd3 || combo !== 8'd3) begin
            fails++; $display("FAIL clear_final: got leds=%h score=%0d combo=%0d expected 0 3 3", LEDs, score, combo);
        end
    endtask

    task automatic test_miss();
        int m = 0;
        mole_positions = '0; cyc();
        mole_positions = 18'h2A000; cyc(); cyc();
        switches[16] = ~switches[16];
        repeat (9) begin
            cyc(); tests++;
            if (obs !== exp_v) begin fails++; $display("FAIL miss_model: got %h expected %h", obs, exp_v); end
            m += int'(miss);
        end
        tests++;
        if (m != 1 || combo !== 8'd0 || miss_count !== 8'd1 || LEDs !== 18'h2A000) begin
            fails++; $display("FAIL miss_final: got m=%0d combo=%0d mc=%0d leds=%h expected 1 0 1 2a000", m, combo, miss_count, LEDs);
        end
    endtask

    task automatic test_multi();
        int nf = 0;
        mole_positions = 18'h38000; cyc(); cyc();
        switches = switches ^ 18'h30000;
        repeat (9) begin
            cyc(); tests++;
            if (obs !== exp_v) begin fails++; $display("FAIL multi_model: got %h expected %h", obs, exp_v); end
            nf += int'(non_full_clear_hit);
        end
        tests++;
        if (nf != 1 || score !== 16'd5 || combo !== 8'd1 || LEDs !== 18'h08000) begin
            fails++; $display("FAIL multi_final: got nf=%0d score=%0d combo=%0d leds=%h expected 1 5 1 08000", nf, score, combo, LEDs);
        end
    endtask

    task automatic test_reset_mid();
        int p = 0;
        switches[17] = 1'b1; reset_n = 1'b0;
        repeat (3) begin
            cyc(); tests++;
            if (obs !== '0) begin fails++; $display("FAIL midreset_zero: got %h expected 0", obs); end
        end
        reset_n = 1'b1;
        repeat (10) begin
            cyc(); tests++;
            if (obs !== exp_v) begin fails++; $display("FAIL midreset_model: got %h expected %h", obs, exp_v); end
            p += int'(miss | non_full_clear_hit | full_clear_hit);
        end
        tests++;
        if (p != 0) begin fails++; $display("FAIL midreset_strike: got %0d pulses expected 0", p); end
    endtask

    task automatic test_glitch();
        int p = 0;
        mole_positions = '0; cyc();
        mole_positions = 18'h2A000; cyc(); cyc();
        switches[17] = ~switches[17];
        repeat (3) cyc();
        switches[17] = ~switches[17];
        repeat (10) begin
            cyc(); tests++;
            if (obs !== exp_v) begin fails++; $display("FAIL glitch_model: got %h expected %h", obs, exp_v); end
            p += int'(miss | non_full_clear_hit | full_clear_hit);
        end
        tests++;
        if (p != 0) begin fails++; $display("FAIL glitch_pulse: got %0d pulses expected 0", p); end
    endtask

    task automatic test_collision();
        logic [SW-1:0] sc = score;
        logic [CW-1:0] cb = combo, mc = miss_count;
        switches[17] = ~switches[17];
        for (int k = 1; k <= 7; k++) begin
            cyc(); tests++;
            if (obs !== exp_v) begin fails++; $display("FAIL collide_model: got %h expected %h", obs, exp_v); end
            if (k == 6) mole_positions = 18'h3F000;
        end
        tests++;
        if (LEDs !== 18'h3F000 || {miss, non_full_clear_hit, full_clear_hit} !== 3'b000 ||
            score !== sc || combo !== cb || miss_count !== mc) begin
            fails++; $display("FAIL collide_final: got leds=%h p=%b s=%0d c=%0d m=%0d expected 3f000 000 %0d %0d %0d",
                              LEDs, {miss, non_full_clear_hit, full_clear_hit}, score, combo, miss_count, sc, cb, mc);
        end
    endtask

    task automatic test_idle();
        int p = 0;
        game_in_progress = 1'b0;
        repeat (2) cyc();
        repeat (2) begin
            switches = switches ^ N'($urandom);
            repeat (8) begin
                cyc(); tests++;
                if (obs !== exp_v) begin fails++; $display("FAIL idle_model: got %h expected %h", obs, exp_v); end
            end
        end
        game_in_progress = 1'b1; mole_positions = N'($urandom);
        repeat (12) begin
            cyc(); tests++;
            if (obs !== exp_v) begin fails++; $display("FAIL idle_start: got %h expected %h", obs, exp_v); end
            p += int'(miss | non_full_clear_hit | full_clear_hit);
        end
        tests++;
        if (p != 0) begin fails++; $display("FAIL idle_strike: got %0d pulses expected 0", p); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            cyc(); tests++;
            if (obs !== exp_v) begin fails++; $display("FAIL random_model c=%0d: got %h expected %h", c, obs, exp_v); end
            reset_n = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 299) == 0) game_in_progress = ~game_in_progress;
            if ($urandom_range(0, 24) == 0) mole_positions = N'($urandom & $urandom);
            if ($urandom_range(0, 5) == 0) switches[$urandom_range(0, N - 1)] ^= 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_full_clear();
        test_miss();
        test_multi();
        test_reset_mid();
        test_glitch();
        test_collision();
        test_idle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hit_judge.md
HIT_JUDGE -- requirements
Module: hit_judge

Interface
REQ-001 Parameter NUM_HOLES, default 18, number of holes, switches and LEDs (range 1-32).
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles needed before a switch level is accepted (range 1-255).
REQ-003 Parameter SCORE_WIDTH, default 16, width of score counter.
REQ-004 Parameter COMBO_WIDTH, default 8, width of combo and miss counters.
REQ-005 clk  input  1  single system clock; all state updates on rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 mole_positions  input  NUM_HOLES  current mole occupancy, one bit per hole.
REQ-008 switches  input  NUM_HOLES  raw asynchronous player switches; any toggle is a strike.
REQ-009 game_in_progress  input  1  high while a game runs.
REQ-010 LEDs  output  NUM_HOLES  moles of current wave not yet hit.
REQ-011 miss  output  1  one-cycle pulse, at least one strike landed on a hole without a live mole.
REQ-012 non_full_clear_hit  output  1  one-cycle pulse, valid hit(s) leaving live moles.
REQ-013 full_clear_hit  output  1  one-cycle pulse, valid hit(s) clearing the last live mole.
REQ-014 score  output  SCORE_WIDTH  total moles hit this game, saturating.
REQ-015 combo  output  COMBO_WIDTH  consecutive hit events without a miss, saturating.
REQ-016 miss_count  output  COMBO_WIDTH  misses this game, saturating.

Function
REQ-017 Each switch bit SHALL pass a two-flop synchroniser, then a per-hole debouncer accepting a new level only after DEBOUNCE_CYCLES consecutive cycles of the synchronised value differing from the accepted level.
REQ-018 Each change of an accepted level (either direction) SHALL produce a one-cycle internal strike for that hole.
REQ-019 A clean switch change first sampled at edge N SHALL produce its output pulse after edge N+2+DEBOUNCE_CYCLES; all outputs are registered.
REQ-020 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no strike.
REQ-021 A registered copy of mole_positions SHALL be kept; any cycle in which mole_positions differs from it is a wave load: live mask <= mole_positions.
REQ-022 Strikes in a wave-load cycle SHALL be discarded (no pulses, no counter change).
REQ-023 Strikes on live holes SHALL clear those live bits; strikes on non-live holes are misses; all strikes in one cycle are resolved together.
REQ-024 If any valid hit occurs and the live mask becomes zero, full_clear_hit SHALL pulse; if valid hits occur and live bits remain, non_full_clear_hit SHALL pulse; never both.
REQ-025 miss SHALL pulse if any strike in the cycle missed, independent of hit pulses in the same cycle.
REQ-026 score SHALL add the number of valid hits in the cycle (popcount), saturating at 2^SCORE_WIDTH-1.
REQ-027 combo SHALL increment by 1 in a cycle with valid hits and no miss, reset to 0 in any cycle with a miss, saturate at 2^COMBO_WIDTH-1.
REQ-028 miss_count SHALL increment by 1 per cycle with miss, saturating at 2^COMBO_WIDTH-1.
REQ-029 A wave loading an all-zero mask SHALL clear LEDs without any pulse.
REQ-030 While game_in_progress is low: live mask held at 0, no pulses, counters hold, debouncers keep tracking so idle toggles produce no strike later.
REQ-031 On the cycle game_in_progress is first sampled high: score, combo, miss_count SHALL clear to 0 and mole_positions SHALL be loaded as a wave.
REQ-032 LEDs SHALL equal the live mask register.

Reset
REQ-033 reset_n low at a clock edge SHALL set LEDs, live mask, score, combo, miss_count to 0 and miss, non_full_clear_hit, full_clear_hit to 0.
REQ-034 Reset SHALL load synchroniser and accepted levels from the current switches value so switches held during reset produce no strike.
REQ-035 Reset asserted mid-debounce or mid-wave SHALL abandon all pending state; recovery needs no extra cycles beyond reset release.

Verification
REQ-036 Game on, moles 18'h2A000, toggle SW[17], SW[15], SW[13] singly -> two non_full_clear_hit pulses then one full_clear_hit, LEDs 0, score 3, combo 3.
REQ-037 Moles 18'h2A000, toggle SW[16] -> miss pulse, combo 0, miss_count 1, LEDs unchanged 18'h2A000.
REQ-038 Moles 18'h38000, toggle SW[17] and SW[16] same cycle -> one non_full_clear_hit, score +2, combo +1, LEDs 18'h08000.
REQ-039 DEBOUNCE_CYCLES=4, SW[17] pulse of 3 cycles -> no pulse; 4+ cycles stable -> one strike exactly 6 cycles after first sampled edge.
REQ-040 Strike timed on mole_positions change cycle -> no pulse, LEDs equal new mask, counters unchanged.
REQ-041 Assert reset_n low mid-game with score 5 and SW held high -> all outputs 0, no strike after release.
